// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: direction/frame inputs and head/state outputs of the snake game sequencer
interface snake_game_ctrl_if;
    logic [3:0] mov;
    logic       frame_pulse;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [1:0] mov_dir;
    logic       dead;
    logic       blink;
    logic       step;
    logic       running;
    modport master (
        output mov, frame_pulse,
        input  head_x, head_y, mov_dir, dead, blink, step, running
    );
    modport slave (
        input  mov, frame_pulse,
        output head_x, head_y, mov_dir, dead, blink, step, running
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: frame-paced snake head stepping with wall death/blink/restart; SNAKE_WRAP_EN wraps walls instead
module snake_game_ctrl #(
    parameter int GRID_W          = 30,
    parameter int GRID_H          = 30,
    parameter int START_X         = 15,
    parameter int START_Y         = 15,
    parameter int FRAMES_PER_STEP = 120,
    parameter int BLINK_FRAMES    = 30
) (
    input logic              clk,
    input logic              rst,
    snake_game_ctrl_if.slave bus
);
    localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [4:0] SX = 5'(START_X);
    localparam logic [4:0] SY = 5'(START_Y);
    localparam logic [4:0] XL = 5'(GRID_W - 1);
    localparam logic [4:0] YL = 5'(GRID_H - 1);
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    state_t        state_q, state_d;
    logic [4:0]    head_x_q, head_x_d, head_y_q, head_y_d;
    logic [1:0]    dir_q, dir_d, pend_q, pend_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          blink_q, blink_d, step_q, step_d;
    logic [1:0]    req;
    logic [4:0]    nx, ny, tx, ty;
    logic          kill, step_edge;
    always_comb begin
        req = bus.mov[3] ? 2'd3 : bus.mov[2] ? 2'd2 : bus.mov[1] ? 2'd1 : 2'd0;
        nx = head_x_q + (pend_q == 2'd0 ? 5'd1 : 5'd0) - (pend_q == 2'd2 ? 5'd1 : 5'd0);
        ny = head_y_q + (pend_q == 2'd1 ? 5'd1 : 5'd0) - (pend_q == 2'd3 ? 5'd1 : 5'd0);
`ifdef SNAKE_WRAP_EN
        tx = nx == 5'd0 ? XL - 5'd1 : nx == XL ? 5'd1 : nx;
        ty = ny == 5'd0 ? YL - 5'd1 : ny == YL ? 5'd1 : ny;
        kill = 1'b0;
`else
        tx = nx;
        ty = ny;
        kill = nx == 5'd0 || nx == XL || ny == 5'd0 || ny == YL;
`endif
        step_edge = bus.frame_pulse && fcnt_q == FLAST;
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        blink_d  = blink_q;
        step_d   = 1'b0;
        case (state_q)
            IDLE: begin
                head_x_d = SX;
                head_y_d = SY;
                fcnt_d   = '0;
                if (|bus.mov) begin
                    dir_d   = req;
                    pend_d  = req;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (|bus.mov && (req ^ dir_q) != 2'b10) pend_d = req;
                if (bus.frame_pulse) fcnt_d = step_edge ? '0 : fcnt_q + 1'b1;
                if (step_edge) begin
                    dir_d = pend_q;
                    if (kill) begin
                        state_d = DEAD;
                        blink_d = 1'b1;
                        bcnt_d  = '0;
                        phase_d = 2'd0;
                    end else begin
                        head_x_d = tx;
                        head_y_d = ty;
                        step_d   = 1'b1;
                    end
                end
            end
            DEAD: begin
                // phase counts completed blink phases; two phases = 2*BLINK_FRAMES frames
                if (bus.frame_pulse) begin
                    bcnt_d  = bcnt_q == BLAST ? '0 : bcnt_q + 1'b1;
                    blink_d = bcnt_q == BLAST ? ~blink_q : blink_q;
                    phase_d = bcnt_q == BLAST && phase_q != 2'd2 ? phase_q + 2'd1 : phase_q;
                end
                if (phase_q == 2'd2 && |bus.mov) begin
                    state_d  = IDLE;
                    head_x_d = SX;
                    head_y_d = SY;
                    dir_d    = 2'd0;
                    pend_d   = 2'd0;
                    fcnt_d   = '0;
                    bcnt_d   = '0;
                    phase_d  = 2'd0;
                    blink_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            head_x_q <= SX;
            head_y_q <= SY;
            dir_q    <= 2'd0;
            pend_q   <= 2'd0;
            fcnt_q   <= '0;
            bcnt_q   <= '0;
            phase_q  <= 2'd0;
            blink_q  <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            blink_q  <= blink_d;
            step_q   <= step_d;
        end
    end
    assign bus.head_x  = head_x_q;
    assign bus.head_y  = head_y_q;
    assign bus.mov_dir = dir_q;
    assign bus.dead    = state_q == DEAD;
    assign bus.blink   = blink_q;
    assign bus.step    = step_q;
    assign bus.running = state_q == RUN;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed checks of stepping, steering, wall death, blink/restart and reset
module tb_snake_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   step_cnt = 0;
    int   s0;
    logic stp;
    snake_game_ctrl_if bus ();
    snake_game_ctrl #(
        .GRID_W(30), .GRID_H(30), .START_X(15), .START_Y(15),
        .FRAMES_PER_STEP(4), .BLINK_FRAMES(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) step_cnt <= step_cnt + int'(bus.step);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask
    task automatic pmov(input logic [3:0] m);
        bus.mov = m;
        cyc();
        bus.mov = 4'd0;
    endtask
    task automatic frame();
        bus.frame_pulse = 1'b1;
        cyc();
        bus.frame_pulse = 1'b0;
        stp = bus.step;
        repeat (9) cyc();
    endtask
    task automatic step4();
        repeat (4) frame();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        bus.mov = 4'd0;
        bus.frame_pulse = 1'b0;
        cyc();
        do_reset();
        chk("rst_x", bus.head_x, 15);
        chk("rst_y", bus.head_y, 15);
        chk("rst_dir", bus.mov_dir, 0);
        chk("rst_run", bus.running, 0);
        chk("rst_dead", bus.dead, 0);
        chk("rst_blink", bus.blink, 0);
        chk("rst_step", bus.step, 0);
        frame();
        chk("idle_hold_x", bus.head_x, 15);
        pmov(4'b0001);
        chk("t1_run", bus.running, 1);
        chk("t1_dir", bus.mov_dir, 0);
        s0 = step_cnt;
        repeat (3) frame();
        chk("t1_nostep3", step_cnt - s0, 0);
        chk("t1_x3", bus.head_x, 15);
        frame();
        chk("t1_step_hi", stp, 1);
        chk("t1_x", bus.head_x, 16);
        chk("t1_y", bus.head_y, 15);
        chk("t1_step_1cyc", step_cnt - s0, 1);
        pmov(4'b0100);
        chk("t2_rev_dir", bus.mov_dir, 0);
        step4();
        chk("t2_rev_x", bus.head_x, 17);
        chk("t2_rev_y", bus.head_y, 15);
        pmov(4'b0010);
        chk("t2_pend_dir", bus.mov_dir, 0);
        step4();
        chk("t2_down_x", bus.head_x, 17);
        chk("t2_down_y", bus.head_y, 16);
        chk("t2_down_dir", bus.mov_dir, 1);
        do_reset();
        pmov(4'b1001);
        chk("t3_dir_up", bus.mov_dir, 3);
        s0 = step_cnt;
        repeat (14) step4();
        chk("t3_y1", bus.head_y, 1);
        chk("t3_steps", step_cnt - s0, 14);
        chk("t3_alive", bus.dead, 0);
        step4();
        chk("t3_dead", bus.dead, 1);
        chk("t3_blink", bus.blink, 1);
        chk("t3_y_hold", bus.head_y, 1);
        chk("t3_nostep", step_cnt - s0, 14);
        chk("t3_notrun", bus.running, 0);
        frame();
        chk("t4_blink_f1", bus.blink, 1);
        frame();
        chk("t4_blink_f2", bus.blink, 0);
        pmov(4'b0001);
        chk("t4_ign_f2", bus.dead, 1);
        frame();
        chk("t4_blink_f3", bus.blink, 0);
        pmov(4'b1000);
        chk("t4_ign_f3", bus.dead, 1);
        frame();
        chk("t4_blink_f4", bus.blink, 1);
        frame();
        pmov(4'b0010);
        chk("t4_restart_dead", bus.dead, 0);
        chk("t4_restart_run", bus.running, 0);
        chk("t4_restart_x", bus.head_x, 15);
        chk("t4_restart_y", bus.head_y, 15);
        chk("t4_restart_dir", bus.mov_dir, 0);
        chk("t4_restart_blink", bus.blink, 0);
        do_reset();
        pmov(4'b0001);
        repeat (3) frame();
        s0 = step_cnt;
        bus.frame_pulse = 1'b1;
        rst = 1'b1;
        cyc();
        bus.frame_pulse = 1'b0;
        rst = 1'b0;
        chk("t5_x", bus.head_x, 15);
        chk("t5_step", bus.step, 0);
        chk("t5_idle", bus.running, 0);
        cyc();
        chk("t5_nostep", step_cnt - s0, 0);
        do_reset();
        pmov(4'b0001);
        repeat (13) step4();
        chk("t6_x28", bus.head_x, 28);
        step4();
`ifdef SNAKE_WRAP_EN
        chk("t6_wrap_x", bus.head_x, 1);
        chk("t6_wrap_step", stp, 1);
        chk("t6_wrap_dead", bus.dead, 0);
`else
        chk("t6_wall_dead", bus.dead, 1);
        chk("t6_wall_x", bus.head_x, 28);
        chk("t6_wall_step", stp, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
